// File: rtl/shifter_pkg.sv
// Shared types and helpers for the iterative shifter and its one-position step.
package shifter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // Shift amounts of WIDTH or more all produce a fully vacated word.
  function automatic int clamp_shamt(input int shamt, input int width);
    return (shamt > width) ? width : shamt;
  endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-position shifter: moves data one bit toward MSB or LSB,
// inserting fill at the vacated end.
module shift_step
  import shifter_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH-1:0] data,
  input  logic             dir,
  input  logic             fill,
  output logic [WIDTH-1:0] next_data
);

  always_comb begin
    if (dir == DIR_RIGHT) begin
      next_data = {fill, data[WIDTH-1:1]};
    end else begin
      next_data = {data[WIDTH-2:0], fill};
    end
  end

endmodule

// File: rtl/iter_shifter.sv
// Handshaked shifter that moves the operand one bit per clock through a single step.
// Define ITER_SHIFTER_ARITH_EN to add in_arith (sign-filling right shifts).
module iter_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH   = 6,
  parameter int SHAMT_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic               in_dir,
`ifdef ITER_SHIFTER_ARITH_EN
  input  logic               in_arith,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data
);

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   data_reg, data_next;
  logic [SHAMT_W-1:0] count_reg, count_next;
  logic               dir_reg, dir_next;
  logic [SHAMT_W-1:0] clamped_shamt;
  logic [WIDTH-1:0]   stepped_data;
  logic               fill_bit;

  assign clamped_shamt = SHAMT_W'(clamp_shamt(int'(in_shamt), WIDTH));

`ifdef ITER_SHIFTER_ARITH_EN
  // Only the sign to replicate is kept; it is zero unless the shift is arithmetic.
  logic sign_fill_reg, sign_fill_next;

  assign fill_bit = (dir_reg == DIR_RIGHT) & sign_fill_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_fill_reg <= 1'b0;
    end else begin
      sign_fill_reg <= sign_fill_next;
    end
  end

  always_comb begin
    sign_fill_next = sign_fill_reg;
    if (state_reg == IDLE && in_valid) begin
      sign_fill_next = in_arith & in_data[WIDTH-1];
    end
  end
`else
  assign fill_bit = 1'b0;
`endif

  shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .data      (data_reg),
    .dir       (dir_reg),
    .fill      (fill_bit),
    .next_data (stepped_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      data_reg  <= '0;
      count_reg <= '0;
      dir_reg   <= DIR_LEFT;
    end else begin
      state_reg <= state_next;
      data_reg  <= data_next;
      count_reg <= count_next;
      dir_reg   <= dir_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    data_next  = data_reg;
    count_next = count_reg;
    dir_next   = dir_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          data_next  = in_data;
          dir_next   = in_dir;
          count_next = clamped_shamt;
          state_next = (clamped_shamt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        data_next  = stepped_data;
        count_next = count_reg - 1'b1;
        if (count_reg == SHAMT_W'(1)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        // Returning to IDLE first keeps a new operand out of the output-handshake cycle.
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign out_data  = data_reg;

endmodule

// File: doc/iter_shifter.md
Name: iter_shifter

Overview:
- Sequential, handshaked logical shifter; the next stage downstream of the team's fixed concatenation shifts.
- Accepts one operand plus a run-time shift amount and direction.
- Shifts one bit position per clock.
- Presents the result on a valid/ready output, so variable shifts reuse one 1-bit datapath instead of a barrel.

Parameters:
WIDTH, 6, operand/result width in bits
SHAMT_W, 3, width of shift-amount input; must satisfy 2**SHAMT_W > WIDTH

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand offered
in_ready  output  1  block can accept operand
in_data  input  WIDTH  operand
in_shamt  input  SHAMT_W  shift amount
in_dir  input  1  0 = left (toward MSB), 1 = right (toward LSB)
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
out_data  output  WIDTH  shifted result

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: state=IDLE, data reg=0, count=0, dir reg=0. Outputs out_valid=0, out_data=0, in_ready=1.
- Reset mid-operation aborts the transaction immediately. No partial result is ever presented.
- FSM states: IDLE, SHIFT, DONE.
- in_ready = (state==IDLE). out_valid = (state==DONE). out_data = data reg, held stable while out_valid=1.
- IDLE: on in_valid && in_ready, capture in_data, in_dir, and count = min(in_shamt, WIDTH).
  - count==0 -> DONE.
  - count!=0 -> SHIFT.
- SHIFT: each edge shifts data reg one position, zero fill, and decrements count.
  - Left: {d[WIDTH-2:0],1'b0}. Right: {1'b0,d[WIDTH-1:1]}.
  - When the decrement takes count from 1 to 0, go to DONE.
- DONE: hold result until out_valid && out_ready, then -> IDLE.
  - No new operand is accepted in the same cycle as the output handshake.
- Latency: out_valid rises max(1, min(shamt,WIDTH)) clocks after the input-handshake edge.
- Throughput: one operation per latency + 2 cycles minimum.
- Boundary conditions:
  - shamt=0 -> result equals operand after 1 cycle.
  - shamt>=WIDTH -> clamped to WIDTH, result all zeros after WIDTH cycles; e.g. shamt=7, WIDTH=6 gives 6 cycles.
  - Input signals are ignored outside IDLE.
  - in_valid may drop at any time before the handshake with no effect.
  - out_ready held low in DONE stalls indefinitely. The result must not change.

Optional Feature:
- Macro: ITER_SHIFTER_ARITH_EN.
- When defined:
  - Adds input port in_arith (1 bit), captured with the operand.
  - A right shift with arith=1 fills with the captured MSB (sign extension) instead of 0.
  - A clamped shift of a negative operand yields all ones.
  - Left shifts are unaffected.
- When undefined: the port is absent and all shifts are logical, zero fill.

Decomposition:
- Package shifter_pkg holds:
  - state typedef (IDLE/SHIFT/DONE)
  - DIR_LEFT=1'b0 and DIR_RIGHT=1'b1 constants
  - clamp helper function min(shamt, WIDTH)
- Sub-module shift_step: purely combinational one-position shifter (data, dir, fill bit -> next data). It is instantiated once and contains no state.

Test Plan:
- in_data=6'b001000, shamt=2, dir=0, out_ready=1 -> out_valid after 2 clocks, out_data=6'b100000. Then in_ready=1 next cycle.
- in_data=6'b001000, shamt=3, dir=1 -> out_valid after 3 clocks, out_data=6'b000001.
- in_data=6'b101101, shamt=0 -> out_valid after 1 clock, out_data=6'b101101. Shamt=7 -> 6 clocks, out_data=6'b000000.
- Backpressure: shamt=1 left on 6'b000011 with out_ready=0 for 5 cycles -> out_data=6'b000110 stable, in_ready=0 throughout. Second in_valid offered during the stall is not accepted.
- Reset: assert rst_n=0 mid-SHIFT (shamt=5) -> out_valid=0, in_ready=1, out_data=0 immediately. A fresh transaction after release completes correctly.
- With ITER_SHIFTER_ARITH_EN: in_data=6'b100100, shamt=2, dir=1, arith=1 -> 6'b111001. Arith=0 -> 6'b001001.
